// File: rtl/cadd_sat_stage.sv
// cadd_sat_stage: saturating requantize stage with a 2-entry skid FIFO after the complex adder.
// Optional `SAT_CNT_EN adds the sat_clr/sat_cnt clipped-sample counter.
module cadd_sat_stage #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 8
`ifdef SAT_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SAT_CNT_EN
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_re,
  input  logic [IN_W-1:0]  in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_re,
  output logic [OUT_W-1:0] out_im,
  output logic             out_sat
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  localparam logic signed [IN_W-1:0] HI = IN_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W-1:0] LO = ~HI;
  function automatic logic [OUT_W:0] sat(input logic signed [IN_W-1:0] x);
    return x > HI ? {1'b1, HI[OUT_W-1:0]} : x < LO ? {1'b1, LO[OUT_W-1:0]} : {1'b0, x[OUT_W-1:0]};
  endfunction
  state_e state_q, state_d;
  logic rd_q, wr_q, rd_d, push, pop;
  logic [OUT_W:0] re_s, im_s;
  logic [2*OUT_W:0] mem_q [2];
  logic [2*OUT_W:0] out_q, new_w, head_d;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign {out_sat, out_re, out_im} = out_q;
  always_comb begin
    re_s    = sat(in_re);
    im_s    = sat(in_im);
    new_w   = {re_s[OUT_W] | im_s[OUT_W], re_s[OUT_W-1:0], im_s[OUT_W-1:0]};
    rd_d    = rd_q ^ pop;
    state_d = (push & ~pop) ? (state_q == EMPTY ? ONE : FULL)
            : (pop & ~push) ? (state_q == FULL ? ONE : EMPTY)
            : state_q;
    // The freshly written entry becomes the head when it lands in the slot rd is about to point at
    head_d  = (push && rd_d == wr_q) ? new_w : mem_q[rd_d];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mem_q   <= '{default: '0};
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_q ^ push;
      if (push) mem_q[wr_q] <= new_w;
      if (state_d != EMPTY) out_q <= head_d;
    end
  end
`ifdef SAT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  assign sat_cnt = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (sat_clr) cnt_q <= '0;
    else if (push && new_w[2*OUT_W] && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_cadd_sat_stage.sv
// tb_cadd_sat_stage: randomized bench for cadd_sat_stage against a queue-based reference model.
module tb_cadd_sat_stage;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic [8:0] in_re = 0, in_im = 0;
  logic in_ready, out_valid, out_sat;
  logic [7:0] out_re, out_im;
`ifdef SAT_CNT_EN
  logic sat_clr = 0;
  logic [15:0] sat_cnt;
  int cnt_m = 0;
`endif
  typedef struct {logic [7:0] re; logic [7:0] im; logic sat;} ent_t;
  ent_t q[$];
  ent_t last;
  int tests = 0, fails = 0;
  wire [18:0] obs = {out_valid, in_ready, out_re, out_im, out_sat};

  cadd_sat_stage dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SAT_CNT_EN
    .sat_clr(sat_clr), .sat_cnt(sat_cnt),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  function automatic ent_t ref_model(input logic [8:0] r, input logic [8:0] i);
    int a, b, ca, cb;
    ent_t e;
    a = $signed(r);
    b = $signed(i);
    ca = a > 127 ? 127 : (a < -128 ? -128 : a);
    cb = b > 127 ? 127 : (b < -128 ? -128 : b);
    e.re = 8'(ca);
    e.im = 8'(cb);
    e.sat = (ca != a) || (cb != b);
    return e;
  endfunction

  function automatic logic [18:0] exp_v();
    ent_t e;
    e = last;
    if (q.size() != 0) e = q[0];
    return {q.size() != 0, q.size() != 2, e.re, e.im, e.sat};
  endfunction

  task automatic clear_model();
    q.delete();
    last = '{8'd0, 8'd0, 1'b0};
`ifdef SAT_CNT_EN
    cnt_m = 0;
`endif
  endtask

  // One clock: decide handshakes from the model, then update it at the edge
  task automatic tick();
    bit push, pop;
    ent_t e;
    push = in_valid && q.size() != 2;
    pop  = q.size() != 0 && out_ready;
    e = ref_model(in_re, in_im);
    @(posedge clk);
    if (pop) begin
      last = q[0];
      void'(q.pop_front());
    end
    if (push) q.push_back(e);
`ifdef SAT_CNT_EN
    if (sat_clr) cnt_m = 0;
    else if (push && e.sat && cnt_m != 65535) cnt_m++;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    clear_model();
    @(negedge clk);
    tests++;
    if (obs !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset: got %h want %h", obs, {1'b0, 1'b1, 8'd0, 8'd0, 1'b0});
    end
`ifdef SAT_CNT_EN
    tests++;
    if (sat_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_cnt: got %0d want 0", sat_cnt);
    end
`endif
  endtask

  task automatic test_single();
    out_ready = 1; in_valid = 1; in_re = 9'd40; in_im = 9'd28;
    tick();
    in_valid = 0;
    tests++;
    if (obs !== {1'b1, 1'b1, 8'd40, 8'd28, 1'b0}) begin
      fails++;
      $display("FAIL single_out: got %h want %h", obs, {1'b1, 1'b1, 8'd40, 8'd28, 1'b0});
    end
    tick();
    tests++;
    if (obs !== exp_v()) begin
      fails++;
      $display("FAIL single_drain: got %h want %h", obs, exp_v());
    end
  endtask

  task automatic test_sat();
    out_ready = 0; in_valid = 1; in_re = 9'(200); in_im = 9'(-200);
    tick();
    in_re = 9'(-129); in_im = 9'(128);
    tick();
    in_valid = 0;
    tests++;
    if ({out_valid, out_re, out_im, out_sat} !== {1'b1, 8'd127, 8'h80, 1'b1}) begin
      fails++;
      $display("FAIL sat_first: got %h want %h", {out_valid, out_re, out_im, out_sat}, {1'b1, 8'd127, 8'h80, 1'b1});
    end
    out_ready = 1;
    tick();
    tests++;
    if ({out_valid, out_re, out_im, out_sat} !== {1'b1, 8'h80, 8'd127, 1'b1}) begin
      fails++;
      $display("FAIL sat_second: got %h want %h", {out_valid, out_re, out_im, out_sat}, {1'b1, 8'h80, 8'd127, 1'b1});
    end
    tick();
    tests++;
    if (obs !== exp_v()) begin
      fails++;
      $display("FAIL sat_drain: got %h want %h", obs, exp_v());
    end
`ifdef SAT_CNT_EN
    tests++;
    if (sat_cnt !== 16'd2) begin
      fails++;
      $display("FAIL sat_cnt: got %0d want 2", sat_cnt);
    end
    sat_clr = 1;
    tick();
    sat_clr = 0;
    tests++;
    if (sat_cnt !== 16'd0) begin
      fails++;
      $display("FAIL sat_clr: got %0d want 0", sat_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    int seen;
    out_ready = 0; in_valid = 1; in_re = 9'd1; in_im = 9'd2;
    tick();
    in_re = 9'd3; in_im = 9'd4;
    tick();
    in_re = 9'd5; in_im = 9'd6;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs !== {1'b1, 1'b0, 8'd1, 8'd2, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got %h want %h", i, obs, {1'b1, 1'b0, 8'd1, 8'd2, 1'b0});
      end
      tick();
    end
    out_ready = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_re == 8'd5) seen++;
      tick();
      if (q.size() != 0 && q[$].re == 8'd5) in_valid = 0;
      tests++;
      if (obs !== exp_v()) begin
        fails++;
        $display("FAIL bp_drain[%0d]: got %h want %h", i, obs, exp_v());
      end
    end
    in_valid = 0;
    tests++;
    if (seen != 1) begin
      fails++;
      $display("FAIL bp_count: got %0d copies of (5,6) want 1", seen);
    end
  endtask

  task automatic test_stream();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_re = 9'($urandom_range(0, 511));
      in_im = 9'($urandom_range(0, 511));
      tick();
      tests++;
      if (obs !== exp_v() || !in_ready || !out_valid) begin
        fails++;
        $display("FAIL stream[%0d]: got %h want %h", i, obs, exp_v());
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_re = 9'($urandom_range(0, 511));
      in_im = 9'($urandom_range(0, 511));
`ifdef SAT_CNT_EN
      sat_clr = $urandom_range(0, 60) == 0;
`endif
      tick();
      tests++;
      if (obs !== exp_v()) begin
        fails++;
        if (errs++ < 10) $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v());
      end
`ifdef SAT_CNT_EN
      tests++;
      if (sat_cnt !== 16'(cnt_m)) begin
        fails++;
        if (errs++ < 10) $display("FAIL random_cnt[%0d]: got %0d want %0d", i, sat_cnt, cnt_m);
      end
`endif
    end
    in_valid = 0;
`ifdef SAT_CNT_EN
    sat_clr = 0;
`endif
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_re = 9'd7; in_im = 9'd9;
    for (int i = 0; i < 4 && q.size() != 2; i++) tick();
    in_valid = 0;
    tests++;
    if (obs !== exp_v() || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ar_full: got %h want %h", obs, exp_v());
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (obs !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL ar_async: got %h want %h", obs, {1'b0, 1'b1, 8'd0, 8'd0, 1'b0});
    end
    clear_model();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
        fails++;
        $display("FAIL ar_after[%0d]: got %h want %h", i, obs, {1'b0, 1'b1, 8'd0, 8'd0, 1'b0});
      end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single();
    test_sat();
    test_backpressure();
    test_stream();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
